// File: rtl/or1200_if_pkg.sv
// Shared constants and fetch-queue entry type for the OR1200 instruction fetch stage.
package or1200_if_pkg;

  localparam int unsigned IF_AW = 32;
  localparam int unsigned IF_DW = 32;

  localparam logic [31:0] KILL_NOP = 32'h1441_0000;
  localparam logic [31:0] IDLE_NOP = 32'h1461_0000;

  localparam logic [3:0] ITAG_TE = 4'hd;
  localparam logic [3:0] ITAG_PE = 4'hc;
  localparam logic [3:0] ITAG_BE = 4'hb;

  // err = {bus error, page fault, tlb miss}
  typedef struct packed {
    logic [IF_DW-1:0] insn;
    logic [IF_AW-1:0] pc;
    logic [2:0]       err;
  } fq_entry_t;

endpackage

// File: rtl/or1200_if_fq_mem.sv
// Circular fetch-queue storage; pointers carry one extra wrap bit so full and empty differ.
module or1200_if_fq_mem
  import or1200_if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_flush,
  input  fq_entry_t                      i_wr_entry,
  output fq_entry_t                      o_rd_entry,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fq_entry_t       r_mem [DEPTH];
  logic [PW:0]     r_wr_ptr;
  logic [PW:0]     r_rd_ptr;
  logic [PW:0]     w_diff;

  assign w_diff     = r_wr_ptr - r_rd_ptr;
  assign o_count    = CW'(w_diff);
  assign o_full     = (o_count == CW'(DEPTH));
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_rd_entry = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush)
      r_mem[r_wr_ptr[PW-1:0]] <= i_wr_entry;
  end

endmodule

// File: rtl/or1200_if_fq.sv
// OR1200 instruction fetch stage with a DEPTH-entry fetch queue and IC backpressure.
// Optional OR1200_IF_FQ_HIWATER_EN adds fq_hiwater (peak occupancy since reset/flush).
module or1200_if_fq
  import or1200_if_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned TAGW  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DW-1:0]               icpu_dat_i,
  input  logic                        icpu_ack_i,
  input  logic                        icpu_err_i,
  input  logic [AW-1:0]               icpu_adr_i,
  input  logic [TAGW-1:0]             icpu_tag_i,
  output logic                        icpu_rdy_o,
  input  logic                        if_freeze,
  input  logic                        if_flushpipe,
  input  logic                        no_more_dslot,
  input  logic                        rfe,
  output logic [DW-1:0]               if_insn,
  output logic [AW-1:0]               if_pc,
  output logic                        if_stall,
  output logic                        except_itlbmiss,
  output logic                        except_immufault,
  output logic                        except_ibuserr,
`ifdef OR1200_IF_FQ_HIWATER_EN
  output logic [$clog2(DEPTH+1)-1:0]  fq_hiwater,
`endif
  output logic [$clog2(DEPTH+1)-1:0]  fq_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic      w_resp;
  logic      w_direct;
  logic      w_push;
  logic      w_pop;
  logic      w_empty;
  logic      w_full;
  logic      w_bypass;
  logic      w_kill;
  logic      r_bypass;
  logic [2:0] w_bus_err;
  logic [2:0] w_sel_err;
  logic [DW-1:0] w_sel_insn;
  logic [AW-1:0] w_bus_pc;
  fq_entry_t w_wr_entry;
  fq_entry_t w_head;
  logic [CW-1:0] w_count;
  logic      w_unused;

  assign w_unused = icpu_adr_i[1];

  assign w_resp   = icpu_ack_i | icpu_err_i;
  assign w_direct = w_empty & w_resp & ~if_freeze;
  assign w_push   = w_resp & icpu_rdy_o & ~if_flushpipe & ~w_direct;
  assign w_pop    = ~if_freeze & ~w_empty & ~if_flushpipe;

  assign w_bus_pc  = {icpu_adr_i[AW-1:2], 2'b00};
  assign w_bus_err = {icpu_err_i & (icpu_tag_i == TAGW'(ITAG_BE)),
                      icpu_err_i & (icpu_tag_i == TAGW'(ITAG_PE)),
                      icpu_err_i & (icpu_tag_i == TAGW'(ITAG_TE))};

  assign w_wr_entry.insn = icpu_err_i ? KILL_NOP : icpu_dat_i;
  assign w_wr_entry.pc   = w_bus_pc;
  assign w_wr_entry.err  = w_bus_err;

  or1200_if_fq_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (if_flushpipe),
    .i_wr_entry (w_wr_entry),
    .o_rd_entry (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign fq_count   = w_count;
  assign icpu_rdy_o = ~w_full;
  assign if_stall   = w_empty & ~w_resp;

  // Restart (adr[0]) suppresses the flush-driven bypass kill.
  assign w_bypass = icpu_adr_i[0] ? 1'b0 : (r_bypass | if_flushpipe);
  assign w_kill   = no_more_dslot | rfe | w_bypass;

  always_comb begin
    w_sel_insn = IDLE_NOP;
    w_sel_err  = w_bus_err;
    if_pc      = w_bus_pc;
    if (!w_empty) begin
      w_sel_insn = w_head.insn;
      w_sel_err  = w_head.err;
      if_pc      = w_head.pc;
    end else if (icpu_ack_i) begin
      w_sel_insn = icpu_dat_i;
    end
  end

  assign if_insn          = w_kill ? KILL_NOP : w_sel_insn;
  assign except_itlbmiss  = ~no_more_dslot & w_sel_err[0];
  assign except_immufault = ~no_more_dslot & w_sel_err[1];
  assign except_ibuserr   = ~no_more_dslot & w_sel_err[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_bypass <= 1'b0;
    else      r_bypass <= w_bypass;
  end

`ifdef OR1200_IF_FQ_HIWATER_EN
  logic [CW-1:0] r_hiwater;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_hiwater <= '0;
    else if (if_flushpipe)        r_hiwater <= '0;
    else if (w_count > r_hiwater) r_hiwater <= w_count;
  end

  assign fq_hiwater = r_hiwater;
`endif

endmodule
